bin2bcd_param: RTL and testbench
================================

# bin2bcd_param

Sequential binary-to-BCD converter that sits directly downstream of `divider_param`. It takes a divider result (quotient or remainder) and converts it to packed decimal digits for display or logging. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It uses the same start/idle handshake style as the divider, so the two can be chained: the divider's `idle` rising edge is qualified into this block's `strt`. The divider's `not_valid` flag is carried through alongside the data.

## Interface
- `WIDTH`, default 32: binary input width in bits.
- `DIGITS`, default 10: number of BCD output digits. Must satisfy DIGITS ≥ ceil(WIDTH·log10(2)); 10 is sufficient for 32 bits.
- `CNT_W`, default 6: bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports (synchronous reset, active-high; one clock):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `strt`  in  1  start request; sampled only while `idle`=1.
- `bin_in`  in  WIDTH  unsigned binary value; latched on an accepted `strt`.
- `nv_in`  in  1  invalid flag from the divider (`not_valid`); latched with `bin_in`.
- `bcd_out`  out  4·DIGITS  packed BCD result; digit 0 (units) is in bits [3:0].
- `nv_out`  out  1  latched `nv_in` of the last completed conversion.
- `done`  out  1  one-cycle pulse when `bcd_out` is updated.
- `idle`  out  1  high when a new `strt` will be accepted.

## Operation
- States: IDLE and CONV.
- **IDLE:**
  - `idle`=1.
  - On `strt`=1: load the shift register with `bin_in`, clear the internal BCD accumulator, set the bit counter to WIDTH, latch `nv_in`, and go to CONV.
- **CONV:**
  - `idle`=0.
  - Each cycle, first add 3 to every accumulator digit that is ≥5, all digits in parallel. Then shift the {accumulator, shift register} pair left by 1, taking in the MSB of the shift register. Then decrement the counter.
  - When the counter reaches 0 after the decrement:
    - copy the accumulator to `bcd_out`
    - copy the latched nv flag to `nv_out`
    - pulse `done`
    - return to IDLE.
- `bcd_out` and `nv_out` hold their previous values for the whole conversion. They change only on the completion edge.
- `strt` while in CONV is ignored. It is neither queued nor does it restart the conversion.
- `strt` held high continuously starts back-to-back conversions. Each new conversion begins on the first cycle `idle` is high again.
- Digit values never exceed 9, so no overflow can occur. Unused upper digits read 0.
- The conversion runs normally when `nv_in`=1. Consumers gate on `nv_out`.

## Timing
- **Reset values:** `bcd_out`=0, `nv_out`=0, `done`=0, `idle`=1. State is IDLE and the counter is 0.
- **`rst` mid-conversion:** the conversion is abandoned at the next edge and all outputs return to their reset values. `rst` takes priority over `strt` on the same edge.
- **Acceptance:** `strt` is accepted at edge E0. `idle` is low from E0 until E_WIDTH.
- **Iterations:** they occur on edges E1..E_WIDTH.
- **Completion:**
  - `bcd_out`, `nv_out` and `done`=1 all become visible after E_WIDTH.
  - `idle`=1 in the same cycle.
  - Latency from accepting `strt` to result is exactly WIDTH cycles; 32 for the defaults.
- **Back-to-back:** the `done` cycle is also an IDLE cycle. A `strt` present in that cycle is accepted, so sustained throughput is one result per WIDTH+1 cycles.
- **`done`:** high for exactly one cycle per completed conversion. It never asserts after reset alone.

## Test plan
- Reset, then `bin_in`=1371 (12339/9), `strt` for 1 cycle. Required: `bcd_out`=0x1371 exactly 32 cycles after acceptance, a single `done` pulse, `idle` low for 32 cycles.
- `bin_in`=8, then after completion `bin_in`=64552 (2959967408/45854). Required: 0x8 then 0x64552. `bcd_out` stays 0x8 throughout the second conversion.
- `bin_in`=32'hFFFFFFFF. Required: `bcd_out`=40'h4294967295. `bin_in`=0 gives `bcd_out`=0 with `done` still pulsing.
- `nv_in`=1 with `bin_in`=0. Required: `nv_out`=1 at completion. A following conversion with `nv_in`=0 clears `nv_out` only at its own completion edge.
- `strt` pulsed again 5 cycles into a conversion. Required: ignored, with the first result unchanged. `strt` held high for 100 cycles: conversions accepted at cycles 0, 33 and 66, with `done` at cycles 32, 65 and 98.
- `rst` asserted 10 cycles into a conversion of 12345. Required: next cycle `idle`=1, `bcd_out`=0, and no `done`. A fresh `strt` then converts correctly.

Source files
------------

// File: rtl/bin2bcd_param.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a start/idle
// handshake matching divider_param; the divider's not_valid flag rides along with the data.
module bin2bcd_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strt_i,
  input  logic [WIDTH-1:0]    bin_in_i,
  input  logic                nv_in_i,
  output logic [4*DIGITS-1:0] bcd_out_o,
  output logic                nv_out_o,
  output logic                done_o,
  output logic                idle_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nv_q, nv_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              nv_out_q, nv_out_d;
  logic              done_q, done_d;
  logic [BcdW-1:0]   acc_adj;

  // Add-3 correction on every digit >= 5, all digits in parallel.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nv_d     = nv_q;
    bcd_d    = bcd_q;
    nv_out_d = nv_out_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strt_i) begin
          shift_d = bin_in_i;
          acc_d   = '0;
          cnt_d   = CntInit;
          nv_d    = nv_in_i;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d   = {acc_adj[BcdW-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d    = {acc_adj[BcdW-2:0], shift_q[WIDTH-1]};
          nv_out_d = nv_q;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      nv_q     <= 1'b0;
      bcd_q    <= '0;
      nv_out_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nv_q     <= nv_d;
      bcd_q    <= bcd_d;
      nv_out_q <= nv_out_d;
      done_q   <= done_d;
    end
  end

  assign bcd_out_o = bcd_q;
  assign nv_out_o  = nv_out_q;
  assign done_o    = done_q;
  assign idle_o    = (state_q == StIdle);

endmodule

// File: tb/tb_bin2bcd_param.sv
// Scoreboard bench for bin2bcd_param: stimulus pushes expected results, a negedge monitor
// pops and compares value, nv flag and completion cycle whenever done is seen.
module tb_bin2bcd_param;

  logic        clk;
  logic        rst;
  logic        strt;
  logic [31:0] bin;
  logic        nv;
  logic [39:0] bcd_o;
  logic        nv_o;
  logic        done_o;
  logic        idle_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [39:0] bcd;
    logic        nv;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [39:0] last_bcd = '0;
  logic        last_nv  = 1'b0;

  bin2bcd_param #(
    .WIDTH (32),
    .DIGITS(10),
    .CNT_W (6)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .strt_i   (strt),
    .bin_in_i (bin),
    .nv_in_i  (nv),
    .bcd_out_o(bcd_o),
    .nv_out_o (nv_o),
    .done_o   (done_o),
    .idle_o   (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done_o), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_out", 64'(bcd_o), 64'(e.bcd));
        chk("nv_out", 64'(nv_o), 64'(e.nv));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One conversion; also checks outputs hold and idle stays low for WIDTH cycles.
  task automatic run_one(input logic [31:0] b, input logic n, input logic [39:0] e);
    int lowcnt;
    bit seen;
    @(negedge clk);
    strt = 1'b1;
    bin  = b;
    nv   = n;
    sb.push_back('{e, n, cyc + 33});
    @(negedge clk);
    strt   = 1'b0;
    lowcnt = 0;
    seen   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_o) begin
        seen = 1;
      end else begin
        if (!idle_o) lowcnt++;
        chk("hold_bcd", 64'(bcd_o), 64'(last_bcd));
        chk("hold_nv", 64'(nv_o), 64'(last_nv));
        @(negedge clk);
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("idle_low_cycles", 64'(lowcnt), 64'(32));
    last_bcd = e;
    last_nv  = n;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int k;
    rst  = 1'b1;
    strt = 1'b0;
    bin  = '0;
    nv   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_bcd", 64'(bcd_o), 64'(0));
    chk("rst_nv", 64'(nv_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_idle", 64'(idle_o), 64'(1));
    repeat (5) @(negedge clk);

    run_one(32'd1371, 1'b0, 40'h1371);
    run_one(32'd8, 1'b0, 40'h8);
    run_one(32'd64552, 1'b0, 40'h64552);
    run_one(32'hFFFF_FFFF, 1'b0, 40'h4294967295);
    run_one(32'd0, 1'b0, 40'h0);
    run_one(32'd0, 1'b1, 40'h0);
    run_one(32'd5, 1'b0, 40'h5);

    // strt during a conversion must be ignored.
    @(negedge clk);
    strt = 1'b1;
    bin  = 32'd77;
    sb.push_back('{40'h77, 1'b0, cyc + 33});
    @(negedge clk);
    strt = 1'b0;
    repeat (4) @(negedge clk);
    strt = 1'b1;
    bin  = 32'd999;
    @(negedge clk);
    strt = 1'b0;
    drain("ignore_drain");
    repeat (40) @(negedge clk);
    chk("ignore_idle", 64'(idle_o), 64'(1));
    chk("ignore_bcd", 64'(bcd_o), 64'(40'h77));

    // strt held high: back-to-back acceptances every WIDTH+1 cycles.
    @(negedge clk);
    k    = cyc;
    strt = 1'b1;
    bin  = 32'd123;
    sb.push_back('{40'h123, 1'b0, k + 33});
    sb.push_back('{40'h123, 1'b0, k + 66});
    sb.push_back('{40'h123, 1'b0, k + 99});
    repeat (99) @(negedge clk);
    strt = 1'b0;
    drain("b2b_drain");
    repeat (40) @(negedge clk);
    chk("b2b_idle", 64'(idle_o), 64'(1));

    // Reset mid-conversion abandons it.
    @(negedge clk);
    strt = 1'b1;
    bin  = 32'd12345;
    @(negedge clk);
    strt = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_idle", 64'(idle_o), 64'(1));
    chk("midrst_bcd", 64'(bcd_o), 64'(0));
    chk("midrst_nv", 64'(nv_o), 64'(0));
    chk("midrst_done", 64'(done_o), 64'(0));
    repeat (40) @(negedge clk);
    last_bcd = '0;
    last_nv  = 1'b0;
    run_one(32'd12345, 1'b0, 40'h12345);

    drain("final_drain");
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
